// File: rtl/onewire_slave_ds18b20.sv
// 1-wire responder emulating a DS18B20: skip-ROM (CC), convert (44) and read scratchpad (BE).
// Define ONEWIRE_SLV_CRC_EN to fill scratchpad byte 8 with the Dallas CRC8 of bytes 0..7.
module onewire_slave_ds18b20 #(
  parameter int unsigned FCLK     = 125,
  parameter int unsigned TRST_MIN = 480,
  parameter int unsigned TPDH     = 30,
  parameter int unsigned TPDL     = 120,
  parameter int unsigned TSAMPLE  = 30,
  parameter int unsigned TRDL     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_i,
  output logic        dq_oe,
  input  logic [15:0] temp_in,
  output logic        conv_start,
  output logic        cmd_valid,
  output logic [7:0]  func_cmd,
  output logic        presence,
  output logic        busy
);
  localparam int TW = (FCLK > 1) ? $clog2(FCLK) : 1;
  localparam int LW = $clog2(TRST_MIN + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RST_LOW = 3'd1;
  localparam logic [2:0] PD_WAIT = 3'd2;
  localparam logic [2:0] PD_LOW  = 3'd3;
  localparam logic [2:0] ROM_RX  = 3'd4;
  localparam logic [2:0] FUNC_RX = 3'd5;
  localparam logic [2:0] TX      = 3'd6;

  logic [2:0]    state;
  logic          dq_meta, dq_sync, dq_prev;
  logic [TW-1:0] tick_cnt;
  logic [LW-1:0] low_cnt;
  logic [7:0]    us_cnt;
  logic [6:0]    bit_cnt;
  logic [7:0]    shift;
  logic          slot, sampled, sample_bit, drive;
  logic [15:0]   temp_lat;
  logic [7:0]    byte8;
  logic [63:0]   sp_low;
  logic [71:0]   scratch;
  logic          edge_seen, fall, tick, tick_wrap, bus_rst, tx_last;
  logic [7:0]    rx_byte;

  assign edge_seen = dq_sync ^ dq_prev;
  assign fall      = dq_prev & ~dq_sync;
  assign tick_wrap = (tick_cnt == TW'(FCLK - 1));
  // Any line edge restarts the prescaler so slot timing is measured from the edge itself.
  assign tick      = tick_wrap & ~edge_seen;
  assign bus_rst   = (low_cnt == LW'(TRST_MIN)) & ~dq_sync & ~drive;
  assign rx_byte   = {sample_bit, shift[7:1]};
  assign tx_last   = (bit_cnt == 7'd71);

  assign sp_low  = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_lat};
  assign scratch = {byte8, sp_low};

`ifdef ONEWIRE_SLV_CRC_EN
  function automatic logic [7:0] crc8(input logic [63:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (crc[0] ^ data[i]) crc = (crc >> 1) ^ 8'h8C;
      else                  crc = crc >> 1;
    end
    return crc;
  endfunction
  assign byte8 = crc8(sp_low);
`else
  assign byte8 = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dq_meta    <= 1'b1;
      dq_sync    <= 1'b1;
      dq_prev    <= 1'b1;
      tick_cnt   <= '0;
      low_cnt    <= '0;
      us_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      slot       <= 1'b0;
      sampled    <= 1'b0;
      sample_bit <= 1'b0;
      drive      <= 1'b0;
      temp_lat   <= 16'h0550;
      func_cmd   <= '0;
      cmd_valid  <= 1'b0;
      conv_start <= 1'b0;
    end else begin
      dq_meta    <= dq_i;
      dq_sync    <= dq_meta;
      dq_prev    <= dq_sync;
      cmd_valid  <= 1'b0;
      conv_start <= 1'b0;

      if (edge_seen || tick_wrap) tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + 1'b1;

      if (dq_sync || drive)                          low_cnt <= '0;
      else if (tick && low_cnt != LW'(TRST_MIN))     low_cnt <= low_cnt + 1'b1;

      if (bus_rst) begin
        state   <= RST_LOW;
        drive   <= 1'b0;
        slot    <= 1'b0;
        sampled <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          RST_LOW: if (dq_sync) begin
            state  <= PD_WAIT;
            us_cnt <= '0;
          end
          PD_WAIT: if (tick) begin
            if (us_cnt == 8'(TPDH - 1)) begin
              state  <= PD_LOW;
              drive  <= 1'b1;
              us_cnt <= '0;
            end else us_cnt <= us_cnt + 1'b1;
          end
          PD_LOW: if (tick) begin
            if (us_cnt == 8'(TPDL - 1)) begin
              state   <= ROM_RX;
              drive   <= 1'b0;
              bit_cnt <= '0;
              slot    <= 1'b0;
              sampled <= 1'b0;
            end else us_cnt <= us_cnt + 1'b1;
          end
          ROM_RX, FUNC_RX: begin
            if (fall) begin
              slot    <= 1'b1;
              sampled <= 1'b0;
              us_cnt  <= '0;
            end else if (slot && tick) begin
              if (!sampled) begin
                us_cnt <= us_cnt + 1'b1;
                if (us_cnt == 8'(TSAMPLE - 1)) begin
                  sampled    <= 1'b1;
                  sample_bit <= dq_sync;
                end
              end else begin
                slot    <= 1'b0;
                sampled <= 1'b0;
                // A line still held low one tick past the sample point discards the slot.
                if (dq_sync) begin
                  shift   <= rx_byte;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 7'd7) begin
                    bit_cnt <= '0;
                    if (state == ROM_RX) begin
                      state <= (rx_byte == 8'hCC) ? FUNC_RX : IDLE;
                    end else begin
                      cmd_valid <= 1'b1;
                      func_cmd  <= rx_byte;
                      if (rx_byte == 8'h44) begin
                        temp_lat   <= temp_in;
                        conv_start <= 1'b1;
                        state      <= IDLE;
                      end else if (rx_byte == 8'hBE) begin
                        state <= TX;
                      end else begin
                        state <= IDLE;
                      end
                    end
                  end
                end
              end
            end
          end
          TX: begin
            if (drive) begin
              if (tick) begin
                if (us_cnt == 8'(TRDL - 1)) begin
                  drive   <= 1'b0;
                  bit_cnt <= tx_last ? 7'd0 : bit_cnt + 1'b1;
                  if (tx_last) state <= IDLE;
                end else us_cnt <= us_cnt + 1'b1;
              end
            end else if (fall) begin
              if (scratch[bit_cnt]) begin
                bit_cnt <= tx_last ? 7'd0 : bit_cnt + 1'b1;
                if (tx_last) state <= IDLE;
              end else begin
                drive  <= 1'b1;
                us_cnt <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dq_oe    = drive & ~rst;
  assign presence = drive & (state == PD_LOW) & ~rst;
  assign busy     = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_onewire_slave_ds18b20.sv
// Bench for onewire_slave_ds18b20: a bus master drives DQ and checks replies against a scratchpad model.
module tb_onewire_slave_ds18b20;
  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        master_low = 1'b0;
  logic        dq;
  logic [15:0] temp_in = 16'h0000;
  logic        dq_oe, conv_start, cmd_valid, presence, busy;
  logic [7:0]  func_cmd;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_conv = 0;
  int n_oe = 0;

  logic [15:0] model_temp = 16'h0550;
  logic [7:0]  exp_sp [9];

  assign dq = ~(master_low | dq_oe);

  onewire_slave_ds18b20 #(.FCLK(F)) dut (
    .clk        (clk),
    .rst        (rst),
    .dq_i       (dq),
    .dq_oe      (dq_oe),
    .temp_in    (temp_in),
    .conv_start (conv_start),
    .cmd_valid  (cmd_valid),
    .func_cmd   (func_cmd),
    .presence   (presence),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid)  n_valid <= n_valid + 1;
    if (conv_start) n_conv  <= n_conv + 1;
    if (dq_oe)      n_oe    <= n_oe + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    logic [7:0] crc;
    logic       fb;
    exp_sp[0] = model_temp[7:0];
    exp_sp[1] = model_temp[15:8];
    exp_sp[2] = 8'h4B;
    exp_sp[3] = 8'h46;
    exp_sp[4] = 8'h7F;
    exp_sp[5] = 8'hFF;
    exp_sp[6] = 8'h0C;
    exp_sp[7] = 8'h10;
    crc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb  = crc[0] ^ exp_sp[i][j];
        crc = {1'b0, crc[7:1]};
        if (fb) crc = crc ^ 8'h8C;
      end
    end
`ifdef ONEWIRE_SLV_CRC_EN
    exp_sp[8] = crc;
`else
    exp_sp[8] = 8'h00;
`endif
  endtask

  // Presence must start 30 us after release and last 120 us.
  task automatic presence_window(input string tag);
    cyc(29 * F);
    check({tag, "/pd_before"}, dq_oe, 0);
    cyc(3 * F);
    check({tag, "/pd_start_oe"}, dq_oe, 1);
    check({tag, "/pd_start_presence"}, presence, 1);
    cyc(118 * F);
    check({tag, "/pd_late_oe"}, dq_oe, 1);
    cyc(3 * F);
    check({tag, "/pd_end_oe"}, dq_oe, 0);
    check({tag, "/pd_end_presence"}, presence, 0);
  endtask

  task automatic bus_reset(input string tag);
    master_low = 1'b1;
    cyc(490 * F);
    master_low = 1'b0;
    presence_window(tag);
  endtask

  task automatic write_bit(input logic b);
    master_low = 1'b1;
    if (b) cyc(5 * F);
    else   cyc(30 * F + 1);
    master_low = 1'b0;
    if (b) cyc(40 * F);
    else   cyc(15 * F - 1);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    master_low = 1'b1;
    cyc(3 * F);
    master_low = 1'b0;
    cyc(9 * F);
    b = dq;
    cyc(33 * F);
  endtask

  task automatic read_scratchpad(input string tag);
    logic [7:0] v;
    logic       b;
    build_model();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) begin
        read_bit(b);
        v[i] = b;
      end
      check($sformatf("%s/byte%0d", tag, k), {24'h0, v}, {24'h0, exp_sp[k]});
    end
    cyc(4);
    check({tag, "/idle_after_tx"}, busy, 0);
  endtask

  initial begin
    int          v0, c0, o0;
    logic [31:0] r;
    logic        b;
    logic [71:0] sp_bits;

    cyc(3);
    check("rst/dq_oe", dq_oe, 0);
    check("rst/presence", presence, 0);
    check("rst/busy", busy, 0);
    check("rst/cmd_valid", cmd_valid, 0);
    check("rst/conv_start", conv_start, 0);
    check("rst/func_cmd", func_cmd, 0);
    rst = 1'b0;
    cyc(5);

    // Short low is not a reset.
    o0 = n_oe;
    master_low = 1'b1;
    cyc(300 * F);
    master_low = 1'b0;
    cyc(200 * F);
    check("short_low/no_presence", n_oe - o0, 0);
    check("short_low/idle", busy, 0);

    bus_reset("t1");
    check("t1/busy_rom_rx", busy, 1);

    v0 = n_valid;
    c0 = n_conv;
    temp_in = 16'h0191;
    write_byte(8'hCC);
    write_byte(8'h44);
    model_temp = 16'h0191;
    cyc(5);
    check("t3/cmd_valid_once", n_valid - v0, 1);
    check("t3/conv_start_once", n_conv - c0, 1);
    check("t3/func_cmd", func_cmd, 8'h44);
    check("t3/idle", busy, 0);

    bus_reset("t4");
    write_byte(8'hCC);
    write_byte(8'hBE);
    check("t4/func_cmd", func_cmd, 8'hBE);
    check("t4/no_conv", n_conv - c0, 1);
    read_scratchpad("t4");

    bus_reset("t5");
    v0 = n_valid;
    write_byte(8'h55);
    cyc(5);
    check("t5/no_cmd_valid", n_valid - v0, 0);
    check("t5/released", dq_oe, 0);
    check("t5/idle", busy, 0);
    check("t5/func_cmd_kept", func_cmd, 8'hBE);
    bus_reset("t5b");

    for (int rnd = 0; rnd < 2; rnd++) begin
      r = $urandom;
      temp_in = r[15:0];
      bus_reset($sformatf("rnd%0d_a", rnd));
      write_byte(8'hCC);
      write_byte(8'h44);
      model_temp = r[15:0];
      temp_in = ~r[15:0];
      bus_reset($sformatf("rnd%0d_b", rnd));
      write_byte(8'hCC);
      write_byte(8'hBE);
      read_scratchpad($sformatf("rnd%0d", rnd));
    end

    // Long master low part-way through a read; the next bit is a 1 so the slave leaves DQ alone.
    bus_reset("t6");
    write_byte(8'hCC);
    write_byte(8'hBE);
    build_model();
    for (int k = 0; k < 9; k++) sp_bits[k*8 +: 8] = exp_sp[k];
    for (int i = 0; i < 22; i++) begin
      read_bit(b);
      check($sformatf("t6/bit%0d", i), {31'h0, b}, {31'h0, sp_bits[i]});
    end
    master_low = 1'b1;
    cyc(490 * F);
    check("t6/oe_low_during_reset", dq_oe, 0);
    check("t6/busy_rst_low", busy, 1);
    cyc(10 * F);
    master_low = 1'b0;
    presence_window("t6");

    // rst during the presence pulse releases everything.
    master_low = 1'b1;
    cyc(490 * F);
    master_low = 1'b0;
    cyc(60 * F);
    check("t6/oe_in_presence", dq_oe, 1);
    rst = 1'b1;
    cyc(1);
    check("t6rst/dq_oe", dq_oe, 0);
    check("t6rst/presence", presence, 0);
    check("t6rst/busy", busy, 0);
    check("t6rst/cmd_valid", cmd_valid, 0);
    check("t6rst/conv_start", conv_start, 0);
    check("t6rst/func_cmd", func_cmd, 0);
    rst = 1'b0;
    model_temp = 16'h0550;
    cyc(5);

    bus_reset("t7");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_scratchpad("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
